// File: rtl/proc_run_ctrl.sv
// Run controller for the single-cycle processor.
// Streams a program into instruction memory, holds the core in reset for
// RESET_CYCLES, releases it, counts run cycles and parks the core in reset
// again on halt, cycle limit or (optionally) a PC breakpoint.
// Optional feature: define PROC_BREAKPOINT_EN to add bp_en/bp_addr/bp_hit.
module proc_run_ctrl #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned MAX_CYCLES   = 1000,
    parameter int unsigned RESET_CYCLES = 2,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              start_up_n,
    input  logic              go,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              proc_start_up,
    input  logic [31:0]       instruction,
    input  logic [31:0]       pc_q,
    output logic [31:0]       cycle_count,
    output logic              busy,
    output logic              done,
`ifdef PROC_BREAKPOINT_EN
    input  logic              bp_en,
    input  logic [31:0]       bp_addr,
    output logic              bp_hit,
`endif
    output logic              timeout
);

    typedef enum logic [2:0] {StIdle, StLoad, StHold, StRun, StDone} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       hold_q;

    logic        transfer;
    logic        last_word;
    logic [31:0] cnt_inc;
    logic        halt_hit;
    logic        limit_hit;
    logic        bp_match;

`ifdef PROC_BREAKPOINT_EN
    // Breakpoint compares the processor's live PC against the armed address
    always_comb begin
        bp_match = bp_en && (pc_q == bp_addr);
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc_q;

    // No breakpoint hardware: runs end only on halt or limit
    always_comb begin
        bp_match = 1'b0;
    end
`endif

    // Handshake, saturating counter increment and run-exit conditions
    always_comb begin
        transfer  = ld_valid & ld_ready;
        // The last slot ends the load even without ld_last; the index never wraps
        last_word = ld_last | (idx_q == {ADDR_W{1'b1}});
        cnt_inc   = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;
        halt_hit  = (instruction == HALT_WORD);
        limit_hit = (MAX_CYCLES != 0) && (cnt_inc == 32'(MAX_CYCLES));
    end

    // Controller FSM with all outputs registered
    always_ff @(posedge clk or negedge start_up_n) begin
        if (!start_up_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            hold_q        <= '0;
            ld_ready      <= 1'b0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            proc_start_up <= 1'b1;
            cycle_count   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
`ifdef PROC_BREAKPOINT_EN
            bp_hit        <= 1'b0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (go) begin
                        state_q     <= StLoad;
                        idx_q       <= '0;
                        ld_ready    <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
`ifdef PROC_BREAKPOINT_EN
                        bp_hit      <= 1'b0;
`endif
                    end
                end
                StLoad: begin
                    if (transfer) begin
                        imem_we    <= 1'b1;
                        imem_wdata <= ld_data;
                        imem_addr  <= idx_q;
                        idx_q      <= idx_q + 1'b1;
                        if (last_word) begin
                            state_q  <= StHold;
                            ld_ready <= 1'b0;
                            hold_q   <= '0;
                        end
                    end
                end
                StHold: begin
                    // First HOLD cycle also carries the final registered imem write
                    if (hold_q == 32'(RESET_CYCLES - 1)) begin
                        state_q       <= StRun;
                        proc_start_up <= 1'b0;
                    end else begin
                        hold_q <= hold_q + 32'd1;
                    end
                end
                StRun: begin
                    cycle_count <= cnt_inc;
                    if (halt_hit || bp_match || limit_hit) begin
                        state_q       <= StDone;
                        proc_start_up <= 1'b1;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        // Halt outranks breakpoint, which outranks the limit
                        timeout       <= !halt_hit && !bp_match;
`ifdef PROC_BREAKPOINT_EN
                        bp_hit        <= !halt_hit && bp_match;
`endif
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
